branch_resolve_unit: RTL and testbench

//  Pipelined successor to the single-cycle branch decision logic. It predicts branches at fetch with a
//  BHT_DEPTH-entry table of 2-bit saturating counters. It resolves branches and jumps in EX by comparing
//  rs1 and rs2 directly. On a wrong prediction it drives a redirect PC, and it trains the table on every

---
 rtl/branch_pkg.sv | 29 ++
 rtl/branch_bht.sv | 43 ++++
 rtl/branch_resolve_unit.sv | 151 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared constants, counter encodings and FSM states for the branch resolve unit.
package branch_pkg;

  localparam logic [2:0] FUNCT3_BRANCH_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BRANCH_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BRANCH_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BRANCH_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BRANCH_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BRANCH_BGEU = 3'b111;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bru_state_e;

  // Saturating step of a 2-bit direction counter.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'b01;
    end
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2-bit counters, combinational read, one synchronous write port
// shared by the init sweep (priority) and the saturating training update.
module branch_bht
  import branch_pkg::*;
#(
  parameter int         DEPTH    = 64,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_VAL = CTR_WNT
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             init_en,
  input  logic [IDX_W-1:0] init_idx,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0]       ctr_mem [DEPTH];
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_data;

  always_comb begin
    wr_en   = init_en | upd_en;
    wr_idx  = upd_idx;
    wr_data = ctr_step(ctr_mem[upd_idx], upd_taken);
    if (init_en) begin
      wr_idx  = init_idx;
      wr_data = INIT_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ctr_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_ctr = ctr_mem[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Fetch-time branch prediction plus EX-stage branch/jump resolution and redirect.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CTR_INIT  = CTR_WNT,
  parameter int         STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  output logic              ready,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_jump,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_imm,
  input  logic [XLEN-1:0]   ex_jump_target,
  input  logic              ex_pred_taken,
  output logic              ex_taken,
  output logic              ex_redirect,
  output logic [XLEN-1:0]   ex_redirect_pc,
  output logic              ex_illegal,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  bru_state_e       state_reg, state_next;
  logic [IDX_W-1:0] sweep_idx_reg, sweep_idx_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= INIT;
      sweep_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_idx_reg <= sweep_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sweep_idx_next = sweep_idx_reg;
    case (state_reg)
      INIT: begin
        sweep_idx_next = sweep_idx_reg + IDX_W'(1);
        if (sweep_idx_reg == IDX_W'(BHT_DEPTH - 1)) begin
          state_next = RUN;
        end
      end
      default: ;
    endcase
  end

  assign ready = (state_reg == RUN);

  logic eq, lt, ltu, cond, upd_en;
  logic [1:0] rd_ctr;

  assign eq  = (ex_rs1 == ex_rs2);
  assign lt  = ($signed(ex_rs1) < $signed(ex_rs2));
  assign ltu = (ex_rs1 < ex_rs2);

  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      FUNCT3_BRANCH_BEQ:  cond = eq;
      FUNCT3_BRANCH_BNE:  cond = !eq;
      FUNCT3_BRANCH_BLT:  cond = lt;
      FUNCT3_BRANCH_BGE:  cond = !lt;
      FUNCT3_BRANCH_BLTU: cond = ltu;
      FUNCT3_BRANCH_BGEU: cond = !ltu;
      default:            cond = 1'b0;
    endcase
  end

  assign ex_illegal = ex_valid && ex_branch && ((ex_funct3[2:1] == 2'b01) || ex_jump);

  // Resolution never consults the table, so it is correct during the init sweep too.
  always_comb begin
    ex_taken       = 1'b0;
    ex_redirect    = 1'b0;
    ex_redirect_pc = ex_pc + XLEN'(4);
    if (ex_valid && !ex_illegal) begin
      if (ex_branch) begin
        ex_taken    = cond;
        ex_redirect = (cond != ex_pred_taken);
        if (cond) begin
          ex_redirect_pc = ex_pc + ex_imm;
        end
      end else if (ex_jump) begin
        ex_taken       = 1'b1;
        ex_redirect    = 1'b1;
        ex_redirect_pc = {ex_jump_target[XLEN-1:1], 1'b0};
      end
    end
  end

  assign upd_en = rst_n && ready && ex_valid && ex_branch && !ex_illegal;

  branch_bht #(
    .DEPTH    (BHT_DEPTH),
    .IDX_W    (IDX_W),
    .INIT_VAL (CTR_INIT)
  ) u_bht (
    .clk       (clk),
    .rd_idx    (if_pc[IDX_W+1:2]),
    .rd_ctr    (rd_ctr),
    .init_en   (state_reg == INIT),
    .init_idx  (sweep_idx_reg),
    .upd_en    (upd_en),
    .upd_idx   (ex_pc[IDX_W+1:2]),
    .upd_taken (cond)
  );

  assign if_pred_taken = ready && (rd_ctr >= CTR_WT);

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches_reg, stat_mispred_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches_reg <= '0;
      stat_mispred_reg  <= '0;
    end else if (upd_en) begin
      stat_branches_reg <= stat_branches_reg + STAT_W'(1);
      if (ex_redirect) begin
        stat_mispred_reg <= stat_mispred_reg + STAT_W'(1);
      end
    end
  end

  assign stat_branches = stat_branches_reg;
  assign stat_mispred  = stat_mispred_reg;
`else
  assign stat_branches = '0;
  assign stat_mispred  = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], ex_jump_target[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push expectations, a monitor checks them.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc = 32'h0;
  logic        if_pred_taken, ready;
  logic        ex_valid = 1'b0, ex_branch = 1'b0, ex_jump = 1'b0;
  logic [2:0]  ex_funct3 = 3'b0;
  logic [31:0] ex_rs1 = 32'h0, ex_rs2 = 32'h0, ex_pc = 32'h0, ex_imm = 32'h0, ex_jump_target = 32'h0;
  logic        ex_pred_taken = 1'b0;
  logic        ex_taken, ex_redirect, ex_illegal;
  logic [31:0] ex_redirect_pc, stat_branches, stat_mispred;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken), .ready(ready),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_jump_target(ex_jump_target), .ex_pred_taken(ex_pred_taken),
    .ex_taken(ex_taken), .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .ex_illegal(ex_illegal), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  typedef struct {
    string       name;
    logic        taken;
    logic        redirect;
    logic        illegal;
    logic        chk_pc;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic vec_live = 1'b0;
  logic ready_m = 1'b0;
  int   m_br = 0;
  int   m_mp = 0;

  always @(negedge clk) begin
    exp_t e;
    if (vec_live) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: output presented with no expectation queued");
      end else begin
        e = sb.pop_front();
        if (ex_taken !== e.taken || ex_redirect !== e.redirect || ex_illegal !== e.illegal ||
            (e.chk_pc && ex_redirect_pc !== e.pc)) begin
          n_err++;
          $display("FAIL %s: got taken=%b redirect=%b illegal=%b pc=%h, required taken=%b redirect=%b illegal=%b pc=%h",
                   e.name, ex_taken, ex_redirect, ex_illegal, ex_redirect_pc,
                   e.taken, e.redirect, e.illegal, e.pc);
        end else begin
          $display("ok   %s: taken=%b redirect=%b illegal=%b pc=%h",
                   e.name, ex_taken, ex_redirect, ex_illegal, ex_redirect_pc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end else begin
      $display("ok   %s: %h", nm, got);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic issue(input string nm, input logic v, input logic br, input logic jp,
                       input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] tgt,
                       input logic pred, input logic e_t, input logic e_r,
                       input logic [31:0] e_pc, input logic e_ill, input logic e_chk_pc);
    exp_t e;
    ex_valid = v; ex_branch = br; ex_jump = jp; ex_funct3 = f3;
    ex_rs1 = rs1; ex_rs2 = rs2; ex_pc = pc; ex_imm = imm; ex_jump_target = tgt;
    ex_pred_taken = pred;
    e.name = nm; e.taken = e_t; e.redirect = e_r; e.illegal = e_ill; e.chk_pc = e_chk_pc; e.pc = e_pc;
    sb.push_back(e);
    if (ready_m && v && br && !e_ill) begin
      m_br++;
      if (e_r) m_mp++;
    end
    vec_live = 1'b1;
    @(posedge clk);
    #1;
    vec_live = 1'b0;
    ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0;
  endtask

  task automatic chk_pred(input string nm, input logic [31:0] pc, input logic req);
    if_pc = pc;
    @(negedge clk);
    chk(nm, {31'b0, if_pred_taken}, {31'b0, req});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string nm);
`ifdef BRANCH_STATS_EN
    chk({nm, "_branches"}, stat_branches, m_br);
    chk({nm, "_mispred"}, stat_mispred, m_mp);
`else
    chk({nm, "_branches"}, stat_branches, 32'h0);
    chk({nm, "_mispred"}, stat_mispred, 32'h0);
`endif
  endtask

  task automatic wait_ready(output int cnt, output logic ok, output logic pred_bad);
    cnt = 0; ok = 1'b0; pred_bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cnt++;
      if (if_pred_taken !== 1'b0) pred_bad = 1'b1;
    end
    @(posedge clk);
    #1;
    if (ok) ready_m = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    logic ok, pred_bad;

    // Reset state
    if_pc = 32'h40;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'b0, ready}, 32'h0);
    chk("reset_pred", {31'b0, if_pred_taken}, 32'h0);
    chk_stats("reset_stats");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    wait_ready(cnt, ok, pred_bad);
    chk("init_ready_seen", {31'b0, ok}, 32'h1);
    chk("init_cycles", cnt, 32'd64);
    chk("init_pred_zero", {31'b0, pred_bad}, 32'h0);
    chk_pred("pred_after_init", 32'h40, 1'b0);

    // Signed vs unsigned compares
    issue("blt_taken",  1,1,0, 3'b100, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 32'h0, 0, 1,1, 32'h120, 0,1);
    issue("bltu_nt",    1,1,0, 3'b110, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 32'h0, 0, 0,0, 32'h104, 0,1);
    issue("bge_nt",     1,1,0, 3'b101, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 32'h0, 1, 0,1, 32'h204, 0,1);
    issue("bgeu_taken", 1,1,0, 3'b111, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 32'h0, 1, 1,0, 32'h240, 0,1);

    // Counter training at pc 0x40
    issue("beq_t1", 1,1,0, 3'b000, 32'd5, 32'd5, 32'h40, 32'h10, 32'h0, 0, 1,1, 32'h50, 0,1);
    chk_pred("pred_40_ctr10", 32'h40, 1'b1);
    issue("beq_t2", 1,1,0, 3'b000, 32'd5, 32'd5, 32'h40, 32'h10, 32'h0, 1, 1,0, 32'h50, 0,1);
    issue("beq_t3", 1,1,0, 3'b000, 32'd5, 32'd5, 32'h40, 32'h10, 32'h0, 1, 1,0, 32'h50, 0,1);
    chk_pred("pred_40_ctr11", 32'h40, 1'b1);
    issue("bne_nt1", 1,1,0, 3'b001, 32'd5, 32'd5, 32'h40, 32'h10, 32'h0, 1, 0,1, 32'h44, 0,1);
    chk_pred("pred_40_ctr10b", 32'h40, 1'b1);
    issue("bne_nt2", 1,1,0, 3'b001, 32'd5, 32'd5, 32'h40, 32'h10, 32'h0, 1, 0,1, 32'h44, 0,1);
    chk_pred("pred_40_ctr01", 32'h40, 1'b0);

    // Address arithmetic wraps
    issue("bne_negimm", 1,1,0, 3'b001, 32'd1, 32'd2, 32'h10, 32'hFFFFFFF0, 32'h0, 0, 1,1, 32'h0, 0,1);
    issue("bltu_wrap",  1,1,0, 3'b110, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h8, 32'h0, 1, 1,0, 32'h4, 0,1);

    // Jump: no table change
    issue("jalr", 1,0,1, 3'b000, 32'd5, 32'd5, 32'h40, 32'h0, 32'h1235, 0, 1,1, 32'h1234, 0,1);
    chk_pred("pred_40_after_jump", 32'h40, 1'b0);

    // Illegal encodings: no redirect, no training
    issue("illegal_f3",    1,1,0, 3'b010, 32'd5, 32'd5, 32'h40, 32'h10, 32'h0, 0, 0,0, 32'h0, 1,0);
    issue("illegal_br_jp", 1,1,1, 3'b000, 32'd5, 32'd5, 32'h40, 32'h10, 32'h0, 0, 0,0, 32'h0, 1,0);
    chk_pred("pred_40_after_illegal", 32'h40, 1'b0);

    // Not valid: quiet outputs, no training
    issue("invalid_beq", 0,1,0, 3'b000, 32'd5, 32'd5, 32'h40, 32'h10, 32'h0, 0, 0,0, 32'h44, 0,1);
    chk_pred("pred_40_after_invalid", 32'h40, 1'b0);

    // Train pc 0x80 so the post-reset sweep is visible
    issue("beq80_t1", 1,1,0, 3'b000, 32'd7, 32'd7, 32'h80, 32'h8, 32'h0, 0, 1,1, 32'h88, 0,1);
    issue("beq80_t2", 1,1,0, 3'b000, 32'd7, 32'd7, 32'h80, 32'h8, 32'h0, 1, 1,0, 32'h88, 0,1);
    chk_pred("pred_80_trained", 32'h80, 1'b1);
    chk_stats("run_stats");

    // Reset mid-RUN restarts the sweep
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_m = 1'b0;
    m_br = 0;
    m_mp = 0;
    @(negedge clk);
    chk("rerst_ready", {31'b0, ready}, 32'h0);
    chk_stats("rerst_stats");
    @(posedge clk);
    #1;
    issue("beq_during_init", 1,1,0, 3'b000, 32'd7, 32'd7, 32'h80, 32'h8, 32'h0, 0, 1,1, 32'h88, 0,1);
    if_pc = 32'h80;
    wait_ready(cnt, ok, pred_bad);
    chk("rerst_ready_seen", {31'b0, ok}, 32'h1);
    chk("rerst_cycles_left", cnt, 32'd62);
    chk("rerst_pred_zero", {31'b0, pred_bad}, 32'h0);
    chk_stats("init_update_dropped");
    chk_pred("pred_80_swept", 32'h80, 1'b0);
    issue("beq80_post", 1,1,0, 3'b000, 32'd7, 32'd7, 32'h80, 32'h8, 32'h0, 0, 1,1, 32'h88, 0,1);
    chk_stats("final_stats");

    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
